// File: rtl/relay_forward_ctrl.sv
// relay_forward_ctrl: buffers slave writes, forwards each through the master after a hold delay.
// Define SAT_INC_EN to make the write increment saturate instead of wrap.
module relay_forward_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDRS_WIDTH     = 15,
  parameter logic [ADDRS_WIDTH-1:0] DEST_ADDR = ADDRS_WIDTH'({3'd1, 12'b0}),
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int HOLD_LEN        = 4,
  parameter int ACK_TIMEOUT_LEN = 8,
  parameter int MAX_RETRY       = 3,
  parameter int INCREMENT       = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_wr_en,
  input  logic [DATA_WIDTH-1:0]      s_din,
  input  logic                       s_req,
  output logic                       s_dv,
  output logic [DATA_WIDTH-1:0]      s_dout,
  output logic                       m_hold,
  output logic                       m_execute,
  output logic [ADDRS_WIDTH-1:0]     m_address,
  output logic [DATA_WIDTH-1:0]      m_din,
  input  logic                       m_dvalid,
  input  logic                       m_master_bsy,
  output logic [DATA_WIDTH-1:0]      disp_value,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       overflow,
  output logic                       err_drop,
  output logic [1:0]                 state
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int RW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [RW-1:0] RMAX     = RW'(MAX_RETRY);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [HOLD_LEN-1:0] HOLD_LAST = '1;
  // Retry SEND cycle completes the 2^N window between execute pulses
  localparam logic [ACK_TIMEOUT_LEN-1:0] ACK_LAST =
    {{(ACK_TIMEOUT_LEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    SEND     = 2'd2,
    WAIT_ACK = 2'd3
  } st_t;

  st_t st;
  logic [HOLD_LEN-1:0]        hold_tmr;
  logic [ACK_TIMEOUT_LEN-1:0] ack_tmr;
  logic [RW-1:0]              retry;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] inc_v;
  logic full, empty, timeout, pop, push;

`ifdef SAT_INC_EN
  logic [DATA_WIDTH:0] inc_sum;
  assign inc_sum = {1'b0, s_din} + (DATA_WIDTH+1)'(INCREMENT);
  assign inc_v   = inc_sum[DATA_WIDTH] ? '1 : inc_sum[DATA_WIDTH-1:0];
`else
  assign inc_v = s_din + DATA_WIDTH'(INCREMENT);
`endif

  assign full    = cnt == FULL_CNT;
  assign empty   = cnt == '0;
  assign timeout = ack_tmr == ACK_LAST;
  assign pop     = (st == WAIT_ACK) &&
                   (m_dvalid || (timeout && retry >= RMAX));
  assign push    = s_wr_en && (!full || pop);

  assign fifo_count = cnt;
  assign m_din      = empty ? '0 : mem[rptr];
  assign s_dout     = disp_value;
  assign state      = st;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= inc_v;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      disp_value <= '0;
      overflow   <= 1'b0;
      s_dv       <= 1'b0;
    end else begin
      s_dv <= s_req | s_wr_en;
      if (s_wr_en) begin
        disp_value <= inc_v;
        if (!push) overflow <= 1'b1;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= IDLE;
      hold_tmr  <= '0;
      ack_tmr   <= '0;
      retry     <= '0;
      m_hold    <= 1'b0;
      m_execute <= 1'b0;
      err_drop  <= 1'b0;
      m_address <= '0;
    end else begin
      m_execute <= 1'b0;
      err_drop  <= 1'b0;
      unique case (st)
        IDLE: begin
          m_hold   <= 1'b0;
          hold_tmr <= '0;
          retry    <= '0;
          if (!empty) st <= HOLD;
        end
        HOLD: begin
          hold_tmr <= hold_tmr + 1'b1;
          if (hold_tmr == HOLD_LAST) m_hold <= 1'b1;
          if (m_hold) st <= SEND;
        end
        SEND: begin
          m_hold <= 1'b1;
          if (!m_master_bsy) begin
            m_execute <= 1'b1;
            m_address <= DEST_ADDR;
            ack_tmr   <= '0;
            st        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          m_hold  <= 1'b1;
          ack_tmr <= ack_tmr + 1'b1;
          if (m_dvalid) begin
            m_hold <= 1'b0;
            st     <= IDLE;
          end else if (timeout) begin
            if (retry < RMAX) begin
              retry <= retry + 1'b1;
              st    <= SEND;
            end else begin
              err_drop <= 1'b1;
              m_hold   <= 1'b0;
              st       <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relay_forward_ctrl.sv
// Bench for relay_forward_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_relay_forward_ctrl;

  localparam int INC = 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       s_wr_en = 1'b0;
  logic [7:0] s_din = '0;
  logic       s_req = 1'b0;
  logic       m_dvalid = 1'b0;
  logic       m_master_bsy = 1'b0;
  logic       s_dv, m_hold, m_execute, overflow, err_drop;
  logic [7:0] s_dout, m_din, disp_value;
  logic [14:0] m_address;
  logic [2:0] fifo_count;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  relay_forward_ctrl dut (
    .clk(clk), .rstn(rstn),
    .s_wr_en(s_wr_en), .s_din(s_din), .s_req(s_req),
    .s_dv(s_dv), .s_dout(s_dout),
    .m_hold(m_hold), .m_execute(m_execute),
    .m_address(m_address), .m_din(m_din),
    .m_dvalid(m_dvalid), .m_master_bsy(m_master_bsy),
    .disp_value(disp_value), .fifo_count(fifo_count),
    .overflow(overflow), .err_drop(err_drop), .state(state)
  );

  function automatic logic [7:0] ref_inc(input logic [7:0] x);
    int s;
    s = int'(x) + INC;
`ifdef SAT_INC_EN
    if (s > 255) s = 255;
`endif
    return 8'(s % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_wr_en = 0; s_req = 0; m_dvalid = 0; m_master_bsy = 0; s_din = '0;
    rstn = 0;
    repeat (2) tick();
    rstn = 1;
    tick();
  endtask

  task automatic write_one(input logic [7:0] d);
    s_wr_en = 1; s_din = d;
    tick();
    s_wr_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (20) tick();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", state); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    n_cmp++; if ({s_dv, m_hold, m_execute, overflow, err_drop} !== 5'b0) begin
      n_bad++; $display("FAIL rst_flags got %b want 00000", {s_dv, m_hold, m_execute, overflow, err_drop}); end
    n_cmp++; if ({s_dout, m_din, disp_value} !== 24'h0) begin
      n_bad++; $display("FAIL rst_data got %h want 000000", {s_dout, m_din, disp_value}); end
    n_cmp++; if (m_address !== 15'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", m_address); end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    write_one(8'h05);
    n_cmp++; if (disp_value !== 8'h06) begin n_bad++; $display("FAIL single_disp got %h want 06", disp_value); end
    n_cmp++; if (s_dv !== 1'b1) begin n_bad++; $display("FAIL single_sdv_hi got %b want 1", s_dv); end
    tick();
    n_cmp++; if (s_dv !== 1'b0) begin n_bad++; $display("FAIL single_sdv_lo got %b want 0", s_dv); end
    n = 0;
    while (state !== 2'd1 && n < 50) begin tick(); n++; end
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL single_hold_entry got %0d want 1", state); end
    n = 0;
    while (m_hold !== 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL single_hold_delay got %0d want 16", n); end
    tick();
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL single_send got %0d want 2", state); end
    n = 0;
    while (m_execute !== 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++; if (m_execute !== 1'b1) begin n_bad++; $display("FAIL single_exec got %b want 1", m_execute); end
    n_cmp++; if (m_din !== 8'h06) begin n_bad++; $display("FAIL single_mdin got %h want 06", m_din); end
    n_cmp++; if (m_address !== 15'h1000) begin n_bad++; $display("FAIL single_addr got %h want 1000", m_address); end
    m_dvalid = 1;
    tick();
    m_dvalid = 0;
    n_cmp++; if (m_execute !== 1'b0) begin n_bad++; $display("FAIL single_exec_width got %b want 0", m_execute); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL single_done_state got %0d want 0", state); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_done_count got %0d want 0", fifo_count); end
    n_cmp++; if (m_hold !== 1'b0) begin n_bad++; $display("FAIL single_done_hold got %b want 0", m_hold); end
  endtask

  task automatic test_overflow();
    int n;
    logic [7:0] e;
    do_reset();
    m_master_bsy = 1;
    for (int i = 0; i < 5; i++) begin
      s_wr_en = 1; s_din = 8'(16 + i);
      tick();
    end
    s_wr_en = 0;
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (disp_value !== ref_inc(8'h14)) begin n_bad++; $display("FAIL ovf_disp got %h want %h", disp_value, ref_inc(8'h14)); end
    repeat (30) tick();
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL ovf_parked got %0d want 2", state); end
    m_master_bsy = 0;
    for (int k = 0; k < 4; k++) begin
      e = ref_inc(8'(16 + k));
      n = 0;
      while (m_execute !== 1'b1 && n < 100) begin tick(); n++; end
      n_cmp++; if (m_execute !== 1'b1 || m_din !== e) begin
        n_bad++; $display("FAIL ovf_order%0d got %h want %h", k, m_din, e); end
      m_dvalid = 1;
      tick();
      m_dvalid = 0;
      n_cmp++; if (fifo_count !== 3'(3 - k)) begin
        n_bad++; $display("FAIL ovf_drain%0d got %0d want %0d", k, fifo_count, 3 - k); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_timeout();
    int t[$];
    int errs;
    errs = 0;
    do_reset();
    write_one(8'h33);
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (m_execute === 1'b1) t.push_back(c);
      if (err_drop === 1'b1) begin
        errs++;
        n_cmp++; if (fifo_count !== 3'd0 || state !== 2'd0) begin
          n_bad++; $display("FAIL to_drop_state got cnt %0d st %0d want 0 0", fifo_count, state); end
      end
    end
    n_cmp++; if (t.size() !== 4) begin n_bad++; $display("FAIL to_exec_count got %0d want 4", t.size()); end
    for (int i = 1; i < t.size(); i++) begin
      n_cmp++; if (t[i] - t[i-1] !== 256) begin
        n_bad++; $display("FAIL to_gap%0d got %0d want 256", i, t[i] - t[i-1]); end
    end
    n_cmp++; if (errs !== 1) begin n_bad++; $display("FAIL to_err_pulses got %0d want 1", errs); end
  endtask

  task automatic test_wrap();
    do_reset();
    write_one(8'hFF);
    n_cmp++; if (disp_value !== ref_inc(8'hFF)) begin n_bad++; $display("FAIL wrap_disp got %h want %h", disp_value, ref_inc(8'hFF)); end
    n_cmp++; if (m_din !== ref_inc(8'hFF)) begin n_bad++; $display("FAIL wrap_mdin got %h want %h", m_din, ref_inc(8'hFF)); end
    write_one(8'hFE);
    n_cmp++; if (disp_value !== 8'hFF) begin n_bad++; $display("FAIL wrap_edge got %h want ff", disp_value); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    write_one(8'h40);
    write_one(8'h41);
    n = 0;
    while (m_execute !== 1'b1 && n < 60) begin tick(); n++; end
    n_cmp++; if (state !== 2'd3 || fifo_count !== 3'd2) begin
      n_bad++; $display("FAIL mid_pre got st %0d cnt %0d want 3 2", state, fifo_count); end
    #1 rstn = 0;
    #1;
    n_cmp++; if ({m_hold, m_execute} !== 2'b00) begin n_bad++; $display("FAIL mid_ctl got %b want 00", {m_hold, m_execute}); end
    n_cmp++; if (fifo_count !== 3'd0 || state !== 2'd0) begin
      n_bad++; $display("FAIL mid_clear got cnt %0d st %0d want 0 0", fifo_count, state); end
    tick();
    rstn = 1;
    n = 0;
    repeat (300) begin tick(); if (m_execute === 1'b1) n++; end
    n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL mid_no_exec got %0d want 0", n); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    bit ovf, pend;
    int dly;
    ovf = 0; pend = 0; dly = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit wr, rq, dv, acc;
      logic [7:0] d;
      wr = (c < 3500) && ($urandom_range(0, 24) == 0);
      rq = ($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      dv = 0;
      if (pend) begin
        if (dly == 0) begin dv = 1; pend = 0; end
        else dly--;
      end
      s_wr_en = wr; s_req = rq; s_din = d; m_dvalid = dv;
      m_master_bsy = ($urandom_range(0, 3) == 0);
      tick();
      acc = wr && (q.size() < 4 || dv);
      if (dv && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(ref_inc(d));
      else if (wr) ovf = 1;
      if (wr) begin
        n_cmp++; if (disp_value !== ref_inc(d)) begin n_bad++; $display("FAIL rnd_disp c%0d got %h want %h", c, disp_value, ref_inc(d)); end
      end
      n_cmp++; if (s_dv !== (wr | rq)) begin n_bad++; $display("FAIL rnd_sdv c%0d got %b want %b", c, s_dv, wr | rq); end
      n_cmp++; if (fifo_count !== 3'(q.size())) begin n_bad++; $display("FAIL rnd_count c%0d got %0d want %0d", c, fifo_count, q.size()); end
      n_cmp++; if (overflow !== ovf) begin n_bad++; $display("FAIL rnd_ovf c%0d got %b want %b", c, overflow, ovf); end
      if (m_execute === 1'b1) begin
        n_cmp++; if (q.size() == 0 || m_din !== q[0]) begin
          n_bad++; $display("FAIL rnd_head c%0d got %h want %h", c, m_din, (q.size() > 0) ? q[0] : 8'h00); end
        pend = 1;
        dly = $urandom_range(0, 20);
      end
    end
    s_wr_en = 0; s_req = 0; m_dvalid = 0; m_master_bsy = 0;
    n_cmp++; if (q.size() !== 0 || fifo_count !== 3'd0) begin
      n_bad++; $display("FAIL rnd_drain got %0d want 0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
